// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM states, baud divider math.
// UART_PARITY_EN adds the PARITY state used by both FSMs.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_OFF  = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [3:0] TICK_MID  = 4'd7;
    localparam logic [3:0] TICK_LAST = 4'd15;

    // Clocks per 16x oversampling tick, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic par_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy output; caller guarantees push/pop legality.
// A push into a full FIFO is allowed only together with a pop.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Buffered UART: TX/RX FIFOs, 16x-oversampled receiver, sticky error flags.
// Define UART_PARITY_EN to honour parity_mode; otherwise frames carry no parity.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 err_clear,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err,
    output logic [LW-1:0]        tx_level,
    output logic [LW-1:0]        rx_level,
    input  logic                 serial_in,
    output logic                 serial_out
);

    localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);
    localparam int DW  = cnt_w(DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_rdata;
    logic                 rx_push, rx_pop, rx_full, rx_empty;

    assign data_in_ready  = ~tx_full;
    assign tx_push        = data_in_valid & ~tx_full;
    assign data_out_valid = ~rx_empty;
    assign rx_pop         = ~rx_empty & data_out_ready;

    uart_state_e          tx_state_q, tx_state_d;
    logic [DW-1:0]        tx_div_q, tx_div_d;
    logic [3:0]           tx_tck_q, tx_tck_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 serial_out_q, serial_out_d;
    logic                 tx_tick, tx_bit_end, tx_load;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
    logic                 tx_pen_q, tx_pen_d;
`endif

    assign tx_tick    = (tx_div_q == DIV_LAST);
    assign tx_bit_end = tx_tick && (tx_tck_q == TICK_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = '0;
        tx_tck_d   = '0;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
        tx_pen_d   = tx_pen_q;
`endif
        if (tx_state_q != ST_IDLE) begin
            tx_div_d = tx_tick ? '0 : tx_div_q + 1'b1;
            tx_tck_d = tx_tck_q + 4'(tx_tick);
        end
        unique case (tx_state_q)
            ST_IDLE: tx_load = ~tx_empty;
            ST_START: begin
                if (tx_bit_end) begin
                    tx_state_d = ST_DATA;
                    tx_bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = tx_pen_q ? ST_PARITY : ST_STOP;
`else
                        tx_state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tx_bit_end) begin
                    tx_bit_d = tx_bit_q + 1'b1;
                    if (tx_bit_q == STOP_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = ST_IDLE;
                        tx_load    = ~tx_empty;
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        // Back-to-back frames: a load at stop end skips IDLE entirely.
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_d = ST_START;
            tx_shift_d = tx_rdata;
            tx_div_d   = '0;
            tx_tck_d   = '0;
            tx_bit_d   = '0;
`ifdef UART_PARITY_EN
            tx_pen_d   = par_on(parity_mode);
            tx_par_d   = ^tx_rdata ^ (parity_mode == PAR_ODD);
`endif
        end
    end

    always_comb begin
        serial_out_d = 1'b1;
        unique case (tx_state_q)
            ST_START:  serial_out_d = 1'b0;
            ST_DATA:   serial_out_d = tx_shift_q[0];
`ifdef UART_PARITY_EN
            ST_PARITY: serial_out_d = tx_par_q;
`endif
            default:   serial_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q   <= ST_IDLE;
            tx_div_q     <= '0;
            tx_tck_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            serial_out_q <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q     <= 1'b0;
            tx_pen_q     <= 1'b0;
`endif
        end else begin
            tx_state_q   <= tx_state_d;
            tx_div_q     <= tx_div_d;
            tx_tck_q     <= tx_tck_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            serial_out_q <= serial_out_d;
`ifdef UART_PARITY_EN
            tx_par_q     <= tx_par_d;
            tx_pen_q     <= tx_pen_d;
`endif
        end
    end

    assign serial_out = serial_out_q;

    uart_state_e          rx_state_q, rx_state_d;
    logic [DW-1:0]        rx_div_q, rx_div_d;
    logic [3:0]           rx_tck_q, rx_tck_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_s1_q, rx_s2_q, rx_last_q;
    logic                 rx_tick, rx_mid, rx_end, rx_done;
    logic                 frame_set, par_set, ovr_set, rx_good;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
`ifdef UART_PARITY_EN
    logic                 rx_pen_q, rx_pen_d;
    logic                 rx_podd_q, rx_podd_d;
    logic                 rx_pbit_q, rx_pbit_d;
    logic                 parity_err_q, parity_err_d;
`else
    logic                 unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    assign rx_tick = (rx_div_q == DIV_LAST);
    assign rx_mid  = rx_tick && (rx_tck_q == TICK_MID);
    assign rx_end  = rx_tick && (rx_tck_q == TICK_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = '0;
        rx_tck_d   = rx_tck_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
`ifdef UART_PARITY_EN
        rx_pen_d   = rx_pen_q;
        rx_podd_d  = rx_podd_q;
        rx_pbit_d  = rx_pbit_q;
`endif
        if (rx_state_q != ST_IDLE) begin
            rx_div_d = rx_tick ? '0 : rx_div_q + 1'b1;
            rx_tck_d = rx_tck_q + 4'(rx_tick);
        end
        unique case (rx_state_q)
            ST_IDLE: begin
                if (rx_last_q && !rx_s2_q) begin
                    rx_state_d = ST_START;
                    rx_tck_d   = '0;
`ifdef UART_PARITY_EN
                    rx_pen_d   = par_on(parity_mode);
                    rx_podd_d  = (parity_mode == PAR_ODD);
`endif
                end
            end
            ST_START: begin
                // Re-align so later samples land every 16 ticks at mid-bit.
                if (rx_mid) begin
                    rx_tck_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_end) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == DATA_LAST) begin
                        rx_bit_d = '0;
`ifdef UART_PARITY_EN
                        rx_state_d = rx_pen_q ? ST_PARITY : ST_STOP;
`else
                        rx_state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (rx_end) begin
                    rx_pbit_d  = rx_s2_q;
                    rx_state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (rx_end) begin
                    rx_done    = 1'b1;
                    rx_state_d = ST_IDLE;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_set = rx_done & ~rx_s2_q;
`ifdef UART_PARITY_EN
        par_set = rx_done & rx_pen_q
                & (rx_pbit_q != (^rx_shift_q ^ rx_podd_q));
`else
        par_set = 1'b0;
`endif
        rx_good       = rx_done & ~frame_set & ~par_set;
        rx_push       = rx_good & (~rx_full | rx_pop);
        ovr_set       = rx_good & rx_full & ~rx_pop;
        frame_err_d   = (frame_err_q & ~err_clear) | frame_set;
        overrun_err_d = (overrun_err_q & ~err_clear) | ovr_set;
`ifdef UART_PARITY_EN
        parity_err_d  = (parity_err_q & ~err_clear) | par_set;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q    <= ST_IDLE;
            rx_div_q      <= '0;
            rx_tck_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_last_q     <= 1'b1;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_pen_q      <= 1'b0;
            rx_podd_q     <= 1'b0;
            rx_pbit_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            rx_state_q    <= rx_state_d;
            rx_div_q      <= rx_div_d;
            rx_tck_q      <= rx_tck_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_s1_q       <= serial_in;
            rx_s2_q       <= rx_s1_q;
            rx_last_q     <= rx_s2_q;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_PARITY_EN
            rx_pen_q      <= rx_pen_d;
            rx_podd_q     <= rx_podd_d;
            rx_pbit_q     <= rx_pbit_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

    uart_sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (tx_push),
        .wdata (data_in),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    uart_sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (rx_push),
        .wdata (rx_shift_q),
        .pop   (rx_pop),
        .rdata (data_out),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

endmodule
